// File: rtl/fdce_response_checker_pkg.sv
// Shared definitions for the FDCE response checker: FSM encoding and the
// default run-shape constants used as parameter defaults by the top.
package fdce_chk_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAKE = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } chk_state_t;

    localparam int DEF_WAKE_CYCLES = 100;
    localparam int DEF_NUM_TESTS   = 10000;
    localparam int DEF_ERR_W       = 16;
    localparam int DEF_IDX_W       = 14;

endpackage

// File: rtl/fdce_response_checker_ref_model.sv
// Golden FDCE: D flip-flop with clock enable and asynchronous active-high
// clear. The clear acts immediately, independent of the clock.
module fdce_ref_model (
    input  logic clk_i,
    input  logic arst_ni,
    input  logic clr_i,
    input  logic clk_en_i,
    input  logic data_i,
    output logic q_o
);

    // Reference flop: async reset/clear win, otherwise load D when enabled.
    always_ff @(posedge clk_i or negedge arst_ni or posedge clr_i) begin
        if (!arst_ni) begin
            q_o <= 1'b0;
        end else if (clr_i) begin
            q_o <= 1'b0;
        end else if (clk_en_i) begin
            q_o <= data_i;
        end
    end

endmodule

// File: rtl/fdce_response_checker.sv
// FDCE response checker: runs a golden FDCE alongside the device under test,
// waits WAKE_CYCLES after start, then compares DUT Q against the model for
// NUM_TESTS cycles, counting mismatches and recording the first failing index.
module fdce_response_checker
    import fdce_chk_pkg::*;
#(
    parameter int WAKE_CYCLES = DEF_WAKE_CYCLES,
    parameter int NUM_TESTS   = DEF_NUM_TESTS,
    parameter int ERR_W       = DEF_ERR_W,
    parameter int IDX_W       = DEF_IDX_W
) (
    input  logic             clk_i,
    input  logic             arst_ni,
    input  logic             start_i,
    input  logic             clr_i,
    input  logic             clk_en_i,
    input  logic             data_i,
    input  logic             dut_q_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             pass_o,
    output logic [ERR_W-1:0] err_cnt_o,
    output logic             first_err_vld_o,
    output logic [IDX_W-1:0] first_err_idx_o
);

    // A zero-length wake phase never uses the counter; keep it one bit wide.
    localparam int WAKE_LAST = (WAKE_CYCLES > 0) ? WAKE_CYCLES - 1 : 0;
    localparam int WAKE_W    = (WAKE_LAST > 0) ? $clog2(WAKE_LAST + 1) : 1;

    chk_state_t        state;
    logic [WAKE_W-1:0] wake_cnt;
    logic [IDX_W-1:0]  test_idx;
    logic              model_q;
    logic              run_start;
    logic              mismatch;

    // Error counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
        return (&v) ? v : v + ERR_W'(1);
    endfunction

    fdce_ref_model u_ref (
        .clk_i    (clk_i),
        .arst_ni  (arst_ni),
        .clr_i    (clr_i),
        .clk_en_i (clk_en_i),
        .data_i   (data_i),
        .q_o      (model_q)
    );

    // A run may be (re)started only from IDLE or DONE; start is ignored otherwise.
    assign run_start = ((state == ST_IDLE) || (state == ST_DONE)) && start_i;
    assign mismatch  = (state == ST_RUN) && (dut_q_i != model_q);

    // Sequencer: IDLE -> WAKE -> RUN -> DONE, with the wake and test counters.
    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            state    <= ST_IDLE;
            wake_cnt <= '0;
            test_idx <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (run_start) begin
                        wake_cnt <= '0;
                        test_idx <= '0;
                        state    <= (WAKE_CYCLES == 0) ? ST_RUN : ST_WAKE;
                    end
                end
                ST_WAKE: begin
                    if (wake_cnt == WAKE_W'(WAKE_LAST)) begin
                        state <= ST_RUN;
                    end else begin
                        wake_cnt <= wake_cnt + WAKE_W'(1);
                    end
                end
                ST_RUN: begin
                    if (test_idx == IDX_W'(NUM_TESTS - 1)) begin
                        state <= ST_DONE;
                    end else begin
                        test_idx <= test_idx + IDX_W'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Run statistics: cleared on start, updated only by RUN-state mismatches.
    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            err_cnt_o       <= '0;
            first_err_vld_o <= 1'b0;
            first_err_idx_o <= '0;
        end else if (run_start) begin
            err_cnt_o       <= '0;
            first_err_vld_o <= 1'b0;
            first_err_idx_o <= '0;
        end else if (mismatch) begin
            err_cnt_o <= sat_inc(err_cnt_o);
            if (!first_err_vld_o) begin
                first_err_vld_o <= 1'b1;
                first_err_idx_o <= test_idx;
            end
        end
    end

    assign busy_o = (state == ST_WAKE) || (state == ST_RUN);
    assign done_o = (state == ST_DONE);
    assign pass_o = done_o && (err_cnt_o == '0);

endmodule
